// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall controller: merges ID/EX/MEM stall requests into the
// per-stage hold vector, tracks outstanding data-memory accesses with a timeout.
module pipe_stall_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id_i,
  input  logic             stallreq_ex_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic [5:0]       stall_o,
  output logic             mem_err_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TIMEOUT_CNT = WCNT_W'(TIMEOUT);

  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [WCNT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic                err_nxt;
  logic                mem_wait;
  logic                timeout;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    err_nxt      = 1'b0;
    mem_wait     = 1'b0;
    timeout      = (state == ST_WAIT) && !mem_ready_i && (wait_cnt == TIMEOUT_CNT);
    case (state)
      ST_IDLE: begin
        if (mem_req_i && !mem_ready_i) begin
          state_nxt    = ST_WAIT;
          wait_cnt_nxt = WCNT_W'(1);
          mem_wait     = 1'b1;
        end
      end
      ST_WAIT: begin
        // mem_req_i is deliberately ignored here: only ready or timeout exit.
        if (mem_ready_i) begin
          state_nxt    = ST_IDLE;
          wait_cnt_nxt = '0;
        end else if (timeout) begin
          state_nxt    = ST_IDLE;
          wait_cnt_nxt = '0;
          err_nxt      = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + WCNT_W'(1);
          mem_wait     = 1'b1;
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // Reset forces the vector to zero at once, even while requests are active.
  always_comb begin
    stall_o = STALL_NONE;
    if (rst)                stall_o = STALL_NONE;
    else if (mem_wait)      stall_o = STALL_MEM;
    else if (stallreq_ex_i) stall_o = STALL_EX;
    else if (stallreq_id_i) stall_o = STALL_ID;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      mem_err_o   <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      mem_err_o <= err_nxt;
      if (stall_o != STALL_NONE)
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

  assign busy_o = (state == ST_WAIT);

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed, table-driven bench for pipe_stall_ctrl: per-cycle vectors plus
// hand-written reset and timeout sequences.
module tb_pipe_stall_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             stallreq_id_i, stallreq_ex_i, mem_req_i, mem_ready_i;
  logic [5:0]       stall_o;
  logic             mem_err_o, busy_o;
  logic [CNT_W-1:0] stall_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [CNT_W-1:0] cnt_model = '0;

  pipe_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id_i(stallreq_id_i),
    .stallreq_ex_i(stallreq_ex_i),
    .mem_req_i    (mem_req_i),
    .mem_ready_i  (mem_ready_i),
    .stall_o      (stall_o),
    .mem_err_o    (mem_err_o),
    .busy_o       (busy_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       id, ex, req, rdy;
    logic [5:0] stall;
    logic       busy, err;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs after negedge, check mid-cycle, then account for
  // the counter increment the upcoming posedge will perform.
  task automatic cycle(input string tag, input logic id, input logic ex, input logic req,
                       input logic rdy, input logic [5:0] exp_stall, input logic exp_busy,
                       input logic exp_err);
    @(negedge clk);
    stallreq_id_i = id;
    stallreq_ex_i = ex;
    mem_req_i     = req;
    mem_ready_i   = rdy;
    #1;
    check({tag, ".stall"}, 64'(stall_o), 64'(exp_stall));
    check({tag, ".busy"},  64'(busy_o),  64'(exp_busy));
    check({tag, ".err"},   64'(mem_err_o), 64'(exp_err));
    check({tag, ".cnt"},   64'(stall_cnt_o), 64'(cnt_model));
    if (exp_stall != 6'b0) cnt_model = cnt_model + 1'b1;
  endtask

  vec_t vecs[$];

  initial begin
    rst = 1'b1;
    stallreq_id_i = 1'b0; stallreq_ex_i = 1'b0; mem_req_i = 1'b0; mem_ready_i = 1'b0;

    // id, ex, req, rdy, stall, busy, err
    vecs.push_back('{0,0,0,0, 6'b000000, 0, 0});  // idle
    vecs.push_back('{1,0,0,0, 6'b000111, 0, 0});  // single-cycle load-use
    vecs.push_back('{0,0,0,0, 6'b000000, 0, 0});
    vecs.push_back('{0,0,1,0, 6'b011111, 0, 0});  // access, ready after 3 cycles
    vecs.push_back('{0,0,1,0, 6'b011111, 1, 0});
    vecs.push_back('{0,0,1,0, 6'b011111, 1, 0});
    vecs.push_back('{0,0,1,1, 6'b000000, 1, 0});
    vecs.push_back('{0,0,0,0, 6'b000000, 0, 0});
    vecs.push_back('{1,1,1,0, 6'b011111, 0, 0});  // MEM masks EX and ID
    vecs.push_back('{1,1,1,0, 6'b011111, 1, 0});
    vecs.push_back('{1,1,1,1, 6'b001111, 1, 0});  // released, EX shows through
    vecs.push_back('{0,1,0,0, 6'b001111, 0, 0});
    vecs.push_back('{1,0,0,0, 6'b000111, 0, 0});
    vecs.push_back('{0,0,1,1, 6'b000000, 0, 0});  // back-to-back zero-wait loads
    vecs.push_back('{0,0,1,1, 6'b000000, 0, 0});
    vecs.push_back('{0,0,1,1, 6'b000000, 0, 0});
    vecs.push_back('{0,1,1,1, 6'b001111, 0, 0});  // zero-wait load with EX busy
    vecs.push_back('{0,0,1,0, 6'b011111, 0, 0});  // req drop in WAIT ignored
    vecs.push_back('{0,0,0,0, 6'b011111, 1, 0});
    vecs.push_back('{0,0,0,1, 6'b000000, 1, 0});
    vecs.push_back('{0,0,0,0, 6'b000000, 0, 0});
    vecs.push_back('{0,0,1,0, 6'b011111, 0, 0});  // req held across return = new access
    vecs.push_back('{0,0,1,1, 6'b000000, 1, 0});
    vecs.push_back('{0,0,1,0, 6'b011111, 0, 0});
    vecs.push_back('{0,0,1,1, 6'b000000, 1, 0});
    vecs.push_back('{0,0,0,0, 6'b000000, 0, 0});

    // Reset state, checked while reset is still asserted.
    #12;
    check("rst.stall", 64'(stall_o), 64'(6'b0));
    check("rst.busy",  64'(busy_o), 64'(1'b0));
    check("rst.err",   64'(mem_err_o), 64'(1'b0));
    check("rst.cnt",   64'(stall_cnt_o), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      cycle($sformatf("vec%0d", i), vecs[i].id, vecs[i].ex, vecs[i].req, vecs[i].rdy,
            vecs[i].stall, vecs[i].busy, vecs[i].err);

    // Timeout: IDLE cycle plus WAIT cycles with wait_cnt 1..15 stall; the
    // wait_cnt==16 cycle releases; error pulses on the following cycle only.
    cycle("to.idle", 0, 0, 1, 0, 6'b011111, 0, 0);
    for (int k = 1; k < TIMEOUT; k++)
      cycle($sformatf("to.wait%0d", k), 0, 0, 1, 0, 6'b011111, 1, 0);
    cycle("to.release", 0, 0, 1, 0, 6'b000000, 1, 0);
    cycle("to.err",     0, 0, 0, 0, 6'b000000, 0, 1);
    cycle("to.after",   0, 0, 0, 0, 6'b000000, 0, 0);

    // Asynchronous reset mid-cycle while in WAIT with the request still active.
    cycle("ar.idle", 0, 0, 1, 0, 6'b011111, 0, 0);
    cycle("ar.wait", 1, 1, 1, 0, 6'b011111, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    check("ar.stall", 64'(stall_o), 64'(6'b0));
    check("ar.busy",  64'(busy_o), 64'(1'b0));
    check("ar.cnt",   64'(stall_cnt_o), 64'(0));
    cnt_model = '0;
    @(negedge clk);
    stallreq_id_i = 1'b0; stallreq_ex_i = 1'b0; mem_req_i = 1'b0; mem_ready_i = 1'b0;
    rst = 1'b0;
    cycle("ar.post0", 0, 0, 0, 0, 6'b000000, 0, 0);
    cycle("ar.post1", 0, 0, 1, 1, 6'b000000, 0, 0);
    cycle("ar.post2", 1, 0, 0, 0, 6'b000111, 0, 0);
    cycle("ar.post3", 0, 0, 0, 0, 6'b000000, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
